// File: rtl/mole_round_engine.sv
// mole_round_engine: one lit mole per round, judges hit/miss/timeout, saturating score and shrinking show time.
module mole_round_engine #(
  parameter int N_MOLES        = 3,
  parameter int SCORE_W        = 8,
  parameter int CNT_W          = 28,
  parameter int GAP_CYCLES     = 150_000_000,
  parameter int SHOW_INIT      = 100_000_000,
  parameter int SHOW_MIN       = 10_000_000,
  parameter int SHOW_STEP      = 10_000_000,
  parameter int HITS_PER_LEVEL = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               game,
  input  logic [N_MOLES-1:0] button,
  output logic [N_MOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               expire_pulse
);
  localparam int IW = $clog2(N_MOLES);
  localparam int HW = HITS_PER_LEVEL > 1 ? $clog2(HITS_PER_LEVEL) : 1;
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(SHOW_INIT);
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(SHOW_MIN);
  localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(SHOW_STEP);
  localparam logic [CNT_W:0]   MIN_STEP = (CNT_W+1)'(SHOW_MIN + SHOW_STEP);
  localparam logic [HW-1:0]    HITS_LAST = HW'(HITS_PER_LEVEL - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t             state_q;
  logic [N_MOLES-1:0] button_q, edges;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   timer_q, show_q, show_dec;
  logic [HW-1:0]      hits_q;
  logic [IW-1:0]      last_q, rnd_idx, pick_idx;

  always_comb begin
    edges    = button & ~button_q;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    rnd_idx  = IW'(lfsr_q % 16'(N_MOLES));
    pick_idx = (rnd_idx == last_q) ? IW'((32'(rnd_idx) + 32'd1) % 32'(N_MOLES)) : rnd_idx;
    // widened compare keeps show_time - step from wrapping below the floor
    show_dec = ({1'b0, show_q} >= MIN_STEP) ? show_q - STEP_C : MIN_C;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      mole         <= '0;
      score        <= '0;
      level        <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      expire_pulse <= 1'b0;
      timer_q      <= '0;
      show_q       <= INIT_C;
      hits_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      last_q       <= '0;
      button_q     <= '0;
    end else begin
      button_q     <= button;
      lfsr_q       <= lfsr_d;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      expire_pulse <= 1'b0;
      if (!game) begin
        state_q <= IDLE;
        mole    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= GAP;
            score   <= '0;
            level   <= '0;
            hits_q  <= '0;
            show_q  <= INIT_C;
            timer_q <= GAP_LD;
          end
          GAP: begin
            if (timer_q != '0) begin
              timer_q <= timer_q - CNT_W'(1);
            end else begin
              mole    <= N_MOLES'(1) << pick_idx;
              last_q  <= pick_idx;
              timer_q <= show_q - CNT_W'(1);
              state_q <= SHOW;
            end
          end
          SHOW: begin
            if (edges[last_q]) begin
              score     <= (score == '1) ? score : score + SCORE_W'(1);
              hit_pulse <= 1'b1;
              mole      <= '0;
              timer_q   <= GAP_LD;
              state_q   <= GAP;
              if (hits_q == HITS_LAST) begin
                hits_q <= '0;
                level  <= (level == 4'd15) ? level : level + 4'd1;
                show_q <= show_dec;
              end else begin
                hits_q <= hits_q + HW'(1);
              end
            end else if (edges != '0) begin
              score      <= (score == '0) ? score : score - SCORE_W'(1);
              miss_pulse <= 1'b1;
            end else if (timer_q == '0) begin
              expire_pulse <= 1'b1;
              mole         <= '0;
              timer_q      <= GAP_LD;
              state_q      <= GAP;
            end else begin
              timer_q <= timer_q - CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mole_round_engine.sv
// tb_mole_round_engine: scoreboarded pulse checks plus directed mole timing, scoring and level checks.
module tb_mole_round_engine;
  logic       clock = 1'b0, reset = 1'b1, game = 1'b0;
  logic [3:0] button = '0;
  logic [3:0] mole, score, level;
  logic       hit_pulse, miss_pulse, expire_pulse;

  mole_round_engine #(
    .N_MOLES(4), .SCORE_W(4), .CNT_W(28), .GAP_CYCLES(4), .SHOW_INIT(8),
    .SHOW_MIN(4), .SHOW_STEP(2), .HITS_PER_LEVEL(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .game(game), .button(button), .mole(mole),
    .score(score), .level(level), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .expire_pulse(expire_pulse)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [1:0] kind; logic [3:0] score; logic [3:0] level;} ev_t;
  localparam logic [1:0] K_HIT = 2'd0, K_MISS = 2'd1, K_EXP = 2'd2;

  ev_t         q[$];
  int          checks = 0, failures = 0;
  logic [15:0] m_lfsr, m_prev;
  int          m_last = 0, m_score = 0, m_level = 0, m_hits = 0, m_show = 8;
  logic [3:0]  lit = '0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clock) begin
    m_lfsr <= reset ? 16'hACE1 : lfsr_step(m_lfsr);
    m_prev <= m_lfsr;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gap();
    int idx;
    for (int i = 0; i < 4; i++) begin
      chk("gap_dark", mole, 0);
      tick();
    end
    idx = int'(m_prev % 16'd4);
    if (idx == m_last) idx = (idx + 1) % 4;
    m_last = idx;
    lit = 4'b0001 << idx;
    chk("mole_lit", mole, lit);
  endtask

  task automatic show_expire(input int s);
    q.push_back({K_EXP, 4'(m_score), 4'(m_level)});
    for (int i = 0; i < s; i++) begin
      chk("show_lit", mole, lit);
      tick();
    end
    chk("expire_dark", mole, 0);
  endtask

  task automatic press_hit(input int delay, input bit multi, input bit hold);
    for (int i = 0; i < delay; i++) begin
      chk("pre_hit_lit", mole, lit);
      tick();
    end
    button = multi ? 4'hF : lit;
    m_score = (m_score == 15) ? 15 : m_score + 1;
    if (m_hits == 1) begin
      m_hits = 0;
      m_level = (m_level == 15) ? 15 : m_level + 1;
      m_show = (m_show - 2 < 4) ? 4 : m_show - 2;
    end else begin
      m_hits++;
    end
    q.push_back({K_HIT, 4'(m_score), 4'(m_level)});
    tick();
    chk("hit_dark", mole, 0);
    if (!hold) button = '0;
  endtask

  task automatic hit_round(input int delay, input bit multi, input bit hold);
    wait_gap();
    press_hit(delay, multi, hold);
  endtask

  task automatic press_wrong(input logic [3:0] b);
    button = b;
    m_score = (m_score == 0) ? 0 : m_score - 1;
    q.push_back({K_MISS, 4'(m_score), 4'(m_level)});
    tick();
    chk("miss_keeps_mole", mole, lit);
    button = '0;
    tick();
    chk("after_miss_lit", mole, lit);
  endtask

  task automatic stimulus();
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_mole", mole, 0);
    chk("rst_score", score, 0);
    chk("rst_level", level, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse, expire_pulse}, 0);
    game = 1'b1;
    tick();
    wait_gap();
    show_expire(8);
    hit_round(2, 0, 0);
    chk("score_after_hit", score, 1);
    wait_gap();
    chk("pre_miss_lit", mole, lit);
    tick();
    press_wrong({lit[2:0], lit[3]});
    press_wrong({lit[1:0], lit[3:2]});
    press_hit(0, 0, 0);
    chk("level_1", level, 1);
    wait_gap();
    show_expire(6);
    hit_round(1, 0, 0);
    hit_round(0, 0, 0);
    hit_round(2, 0, 0);
    hit_round(1, 0, 0);
    chk("level_3", level, 3);
    wait_gap();
    show_expire(4);
    for (int i = 0; i < 28; i++) hit_round(i % 4, i == 5, 0);
    chk("score_sat", score, 15);
    chk("level_sat", level, 15);
    hit_round(1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      wait_gap();
      show_expire(4);
    end
    button = '0;
    chk("held_score", score, 15);
    wait_gap();
    tick();
    game = 1'b0;
    tick();
    chk("drop_dark", mole, 0);
    chk("drop_score_held", score, 15);
    chk("drop_level_held", level, 15);
    repeat (3) begin
      tick();
      chk("idle_dark", mole, 0);
    end
    game = 1'b1;
    m_score = 0; m_level = 0; m_hits = 0; m_show = 8;
    tick();
    chk("restart_score", score, 0);
    chk("restart_level", level, 0);
    wait_gap();
    press_hit(2, 0, 0);
    wait_gap();
    tick();
    reset = 1'b1;
    button = lit;
    tick();
    chk("midrst_mole", mole, 0);
    chk("midrst_score", score, 0);
    chk("midrst_level", level, 0);
    chk("midrst_pulses", {hit_pulse, miss_pulse, expire_pulse}, 0);
    m_score = 0; m_level = 0; m_hits = 0; m_show = 8; m_last = 0;
    reset = 1'b0;
    button = '0;
    tick();
    wait_gap();
    show_expire(8);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic monitor();
    ev_t e;
    logic [1:0] kind;
    forever begin
      @(negedge clock);
      if (hit_pulse || miss_pulse || expire_pulse) begin
        chk("pulse_onehot", $countones({hit_pulse, miss_pulse, expire_pulse}), 1);
        kind = hit_pulse ? K_HIT : (miss_pulse ? K_MISS : K_EXP);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", kind, e.kind);
          chk("pulse_score", score, e.score);
          chk("pulse_level", level, e.level);
        end
      end
    end
  endtask

  initial begin
    fork
      stimulus();
      monitor();
      begin
        repeat (20000) @(posedge clock);
        checks++;
        failures++;
        $display("FAIL timeout: got 20000 cycles expected completion");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mole_round_engine.md
# mole_round_engine

Parametrised round engine for the whack-a-mole game. It lights exactly one of `N_MOLES` moles per round, judges player presses as hit, wrong press or timeout, and keeps a saturating score. It shortens the mole show time as the player levels up. It sits between the board I/O (keys/LEDs) and the seven-segment score display, and replaces the fixed three-mole display/player pair with a single fully synchronous block.

## Interface
Parameters:
- `N_MOLES`, 3: number of moles/buttons, legal 2..16
- `SCORE_W`, 8: score width
- `CNT_W`, 28: round timer width
- `GAP_CYCLES`, 150_000_000: dark gap between rounds, in cycles (≥1)
- `SHOW_INIT`, 100_000_000: initial mole show time, in cycles
- `SHOW_MIN`, 10_000_000: floor for show time (≤ `SHOW_INIT`)
- `SHOW_STEP`, 10_000_000: show-time reduction per level-up
- `HITS_PER_LEVEL`, 5: hits needed to level up (≥1)
- `LFSR_SEED`, 16'hACE1: non-zero LFSR reset value

Ports:
- `clock`, in, 1: system clock
- `reset`, in, 1: synchronous, active-high reset
- `game`, in, 1: level-sensitive run enable
- `button`, in, `N_MOLES`: active-high presses, already synchronised and debounced
- `mole`, out, `N_MOLES`: one-hot lit mole, or all zero
- `score`, out, `SCORE_W`: current score
- `level`, out, 4: current level, starting at 0
- `hit_pulse`, out, 1: one-cycle strobe on a hit
- `miss_pulse`, out, 1: one-cycle strobe on a wrong press
- `expire_pulse`, out, 1: one-cycle strobe on a round timeout

## Operation
- Clock and reset: single clock domain `clock`. `reset` is synchronous and active-high.
- Reset values: state IDLE, `mole`=0, `score`=0, `level`=0, all pulses 0, timer 0, `show_time`=`SHOW_INIT`, hit counter 0, LFSR=`LFSR_SEED`, `last_idx`=0, `button_q`=0.
- Edge detection:
  - `button_q` <= `button` every cycle in every state.
  - `edges` = `button & ~button_q`.
  - Held buttons never re-trigger.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle while not in reset.
- Mole selection: `idx` = `lfsr % N_MOLES`. If `idx == last_idx`, use `(idx+1) % N_MOLES` instead, so the same mole never appears twice in a row. `last_idx` <= chosen index.
- FSM states: IDLE, GAP, SHOW.
  - **IDLE**: `mole`=0. When `game`=1, go to GAP. On entry to GAP from IDLE: clear `score`, `level` and the hit counter, set `show_time`=`SHOW_INIT`, load timer=`GAP_CYCLES-1`.
  - **GAP**: `mole`=0 and presses are ignored. While timer≠0, decrement it. When timer=0: choose a mole, drive `mole`=1<<idx, load timer=`show_time-1`, go to SHOW.
  - **SHOW**: priority order per cycle:
    1. `edges[idx]`=1 is a hit. Score +1, saturating at 2^`SCORE_W`-1. Assert `hit_pulse`. Clear `mole`, load timer=`GAP_CYCLES-1`, go to GAP.
    2. Otherwise `edges`≠0 is a wrong press. Score −1, floored at 0. Assert `miss_pulse`. Stay in SHOW; the mole and timer are unaffected.
    3. Otherwise timer=0 is a timeout. Score is unchanged. Assert `expire_pulse`, clear `mole`, reload the gap timer, go to GAP.
    4. Otherwise decrement the timer.
- Level-up: when a hit occurs and the hit counter = `HITS_PER_LEVEL-1`:
  - hit counter <= 0;
  - `level` <= min(`level`+1, 15);
  - `show_time` <= max(`show_time`−`SHOW_STEP`, `SHOW_MIN`), with underflow-safe compare.
  - Otherwise a hit increments the hit counter.
  - The new `show_time` applies from the next round.
- `game` low in any state: go to IDLE on the next edge, `mole`=0, no pulses. `score` and `level` hold for display until the next game start.

## Timing
- All outputs are registered.
- A button rising edge sampled at clock edge k is reflected in `mole`, `score` and the pulses after edge k (one-cycle latency from the input change).
- GAP lasts exactly `GAP_CYCLES` cycles. SHOW lasts exactly `show_time` cycles if no hit occurs. `mole` is high for exactly those cycles.
- A hit on the same cycle the timer reaches 0 counts as a hit: no `expire_pulse`.
- A hit edge together with other edges in the same cycle counts as a hit only.
- `reset` overrides `game` and every event on the same edge.
- Pulses are never asserted for more than one cycle. At most one of the three pulses is high per cycle.

## Test plan
Bench parameters: `N_MOLES`=4, `GAP_CYCLES`=4, `SHOW_INIT`=8, `SHOW_MIN`=4, `SHOW_STEP`=2, `HITS_PER_LEVEL`=2, `SCORE_W`=4.
- Reset, then raise `game` -> `mole`=0 for 4 cycles after GAP entry, then exactly one bit set for 8 cycles, then `expire_pulse`=1 for one cycle with `score`=0.
- Press the lit mole 2 cycles into SHOW -> `hit_pulse` one cycle later, `score`=1, `mole`=0, new round after 4 gap cycles with a different index.
- Press a wrong button while `score`=1, then the lit button -> `miss_pulse`, `score`=0, then `hit_pulse`, `score`=1. A wrong press at `score`=0 leaves it at 0.
- Make 2 hits -> `level`=1 and next SHOW is 6 cycles. After 6 hits, `level`=3 and SHOW stays 4 cycles (floor).
- Force 15 hits then one more -> `score` stays 15. Hold the lit button across rounds -> no further hits.
- Drop `game` mid-SHOW -> `mole`=0 next cycle and `score` held. Raise `game` -> `score`=0 and `level`=0 on GAP entry. Assert `reset` mid-SHOW -> all reset values next cycle.
